nrisc_wishbone_arbiter: RTL and testbench
=========================================

# nrisc_wishbone_arbiter

Round-robin Wishbone bus arbiter for NRISC-Aurora.
- Sits between up to N_MSTR Wishbone masters (CPU fetch, CPU data, DMA, debug) and the single shared slave port of the NRISC Wishbone slave.
- Grants exactly one master at a time and honours LOCK for atomic sequences.
- Gates the selected strobe onto the slave.
- Ends hung transfers with a timeout error.
- Data, address, SEL and tag muxing sit in the fabric and are driven by WSHARB_GNTIDX.

## Interface
Parameters:
- N_MSTR, 4: number of masters, 2..8.
- TIMEOUT, 255: maximum number of strobe cycles without a termination before an error is forced; 1..65535.

Ports:
- WSHARB_CLKIN  in  1  single clock; all logic on the rising edge.
- WSHARB_RSTIN  in  1  reset; synchronous, active-high.
- WSHARB_CYCIN  in  N_MSTR  per-master CYC (bus request).
- WSHARB_STBIN  in  N_MSTR  per-master STB.
- WSHARB_LOCKIN  in  N_MSTR  per-master LOCK.
- WSHARB_ACKIN  in  1  slave ACK.
- WSHARB_ERRIN  in  1  slave ERR.
- WSHARB_RETRYIN  in  1  slave RTY.
- WSHARB_GNT  out  N_MSTR  one-hot grant, registered.
- WSHARB_GNTIDX  out  $clog2(N_MSTR)  binary index of the granted master, registered.
- WSHARB_STBOUT  out  1  strobe to the slave.
- WSHARB_ERROUT  out  1  timeout error to the granted master; 1-cycle pulse.

## Operation
- The state machine has three states: IDLE, OWN and TOERR.
- **IDLE.** If any CYCIN bit is set:
  - Select the first requester searching from ptr+1 upward, modulo N_MSTR.
  - Register GNT/GNTIDX, set ptr to the selected index, and go to OWN.
  - If no CYCIN bit is set, stay in IDLE with GNT=0.
- **OWN.** Leave OWN on the first matching condition, checked in this order:
  - Owner CYCIN=0 and owner LOCKIN=0: go to IDLE and clear GNT.
  - Owner CYCIN=0 and owner LOCKIN=1: keep the grant. This is the locked gap between cycles.
  - RETRYIN=1 with owner LOCKIN=0 and another CYCIN bit set: go to IDLE and clear GNT. This yields the bus for fairness.
  - RETRYIN=1 with owner LOCKIN=1: keep the grant.
  - Timeout counter reaches TIMEOUT: go to TOERR.
- **TOERR.** Assert ERROUT for exactly one cycle, clear the counter, and return to OWN.
- **STBOUT** is combinational: |(STBIN & GNT) when the state is OWN, otherwise 0. STBOUT is forced to 0 in IDLE and TOERR.
- **Timeout counter** (width $clog2(TIMEOUT+1)):
  - Increments each OWN cycle where STBOUT=1 and ACKIN, ERRIN and RETRYIN are all 0.
  - Clears on any termination, when STBOUT=0, and on leaving OWN.
  - Saturates; it does not wrap.
- Only the owner's inputs are ever examined. Terminations (ACK/ERR/RTY) that arrive while the state is IDLE are ignored.

## Timing
- **Reset values:** GNT=0, GNTIDX=0, ERROUT=0, STBOUT=0, state=IDLE, counter=0, ptr=N_MSTR-1, so master 0 wins the first arbitration.
- **Grant latency:** CYCIN sampled high at edge n gives GNT valid after edge n+1.
- **Release:**
  - Owner CYC low at edge n clears GNT after edge n+1.
  - The earliest next grant is after edge n+2. One dead cycle between owners is mandatory.
- **Timeout:**
  - ERROUT rises after the edge on which the counter equals TIMEOUT, i.e. TIMEOUT+1 cycles after an unterminated STBOUT first goes high.
  - STBOUT is low during the ERROUT cycle.
- **Simultaneous termination and timeout:** a termination in the same cycle the counter would hit TIMEOUT wins; no error is raised.
- **Reset mid-transfer:** RSTIN high at any edge returns all registers to reset values on that edge. The grant is dropped even if LOCK is held.

## Structure
- Shared package const.v:
  - Add the state encodings `ARB_IDLE=2'd0`, `ARB_OWN=2'd1`, `ARB_TOERR=2'd2`.
  - Add the `N_MSTR` default next to the existing `TAM` and `N_DData`.
- One sub-module, nrisc_rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector and ptr.
  - Outputs: one-hot result, binary index and a valid flag.
  - Reusable for the interrupt controller.
- The state machine, counter and ptr stay in nrisc_wishbone_arbiter.

## Test plan
- **Reset and first grant:** after reset, CYCIN=4'b1111 gives GNT=4'b0001 and GNTIDX=0 after one edge. Master 0 holds CYC for 3 ACKed beats; after it drops, GNT=4'b0010 two edges later.
- **Round-robin fairness:** all masters request continuously and each drops CYC after 1 beat. The grant order is 0,1,2,3,0, and each master gets exactly 25% of grants over 40 transfers.
- **LOCK hold:** master 2 owns with LOCKIN=1, drops CYC for 3 cycles, and master 1 requests throughout. GNT stays 4'b0100; master 1 is granted only after LOCK and CYC both drop.
- **Retry yield:** master 0 owns unlocked, master 3 requests, and the slave asserts RETRYIN. GNT=0 after the next edge and GNT=4'b1000 one edge later; with LOCKIN=1, GNT stays 4'b0001.
- **Timeout:** TIMEOUT=4 and master 1 strobes with no slave response. ERROUT pulses exactly once, 5 cycles after STBOUT rises, and STBOUT=0 in that cycle. A variant with ACKIN in the counter==4 cycle shows no ERROUT.
- **Reset mid-locked-transfer:** RSTIN pulses while master 3 owns with LOCK. All outputs return to 0 on that edge, and the next grant goes to master 0.

Source files
------------

// File: rtl/nrisc_wishbone_arbiter_pkg.sv
// Shared constants and types for the NRISC-Aurora bus fabric.
// Holds bus widths, the arbiter master-count default and its FSM encoding.
package nrisc_wishbone_arbiter_pkg;

  localparam int TAM        = 32;
  localparam int N_DData    = 32;
  localparam int N_MSTR_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_TOERR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/nrisc_rr_pick.sv
// Round-robin priority encoder: first set req bit after ptr, wrapping.
// Ports: req, ptr in; hot (one-hot), idx (binary), vld out. Combinational.
module nrisc_rr_pick
  import nrisc_wishbone_arbiter_pkg::*;
#(
  parameter int N  = N_MSTR_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  hot,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    hot = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = IW'((int'(ptr) + i) % N);
        vld = 1'b1;
      end
    end
    if (vld) hot[idx] = 1'b1;
  end

endmodule

// File: rtl/nrisc_wishbone_arbiter.sv
// Round-robin Wishbone arbiter with LOCK, retry yield and timeout error.
// Ports: per-master CYC/STB/LOCK, slave ACK/ERR/RTY in; GNT, GNTIDX, STBOUT, ERROUT out.
module nrisc_wishbone_arbiter
  import nrisc_wishbone_arbiter_pkg::*;
#(
  parameter int N_MSTR  = N_MSTR_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                      WSHARB_CLKIN,
  input  logic                      WSHARB_RSTIN,
  input  logic [N_MSTR-1:0]         WSHARB_CYCIN,
  input  logic [N_MSTR-1:0]         WSHARB_STBIN,
  input  logic [N_MSTR-1:0]         WSHARB_LOCKIN,
  input  logic                      WSHARB_ACKIN,
  input  logic                      WSHARB_ERRIN,
  input  logic                      WSHARB_RETRYIN,
  output logic [N_MSTR-1:0]         WSHARB_GNT,
  output logic [$clog2(N_MSTR)-1:0] WSHARB_GNTIDX,
  output logic                      WSHARB_STBOUT,
  output logic                      WSHARB_ERROUT
);

  localparam int IW = $clog2(N_MSTR);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TOV = CW'(TIMEOUT);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [N_MSTR-1:0] pick_hot;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            own_cyc;
  logic            own_lock;
  logic            others;
  logic            term;

  nrisc_rr_pick #(
    .N  (N_MSTR),
    .IW (IW)
  ) u_pick (
    .req (WSHARB_CYCIN),
    .ptr (ptr),
    .hot (pick_hot),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign own_cyc  = WSHARB_CYCIN[WSHARB_GNTIDX];
  assign own_lock = WSHARB_LOCKIN[WSHARB_GNTIDX];
  assign others   = |(WSHARB_CYCIN & ~WSHARB_GNT);
  assign term     = WSHARB_ACKIN | WSHARB_ERRIN | WSHARB_RETRYIN;

  assign WSHARB_STBOUT = (state == ARB_OWN) &&
                         |(WSHARB_STBIN & WSHARB_GNT);

  // Counts unterminated strobe cycles; holds at TOV instead of wrapping.
  always_comb begin
    cnt_nxt = '0;
    if (WSHARB_STBOUT && !term)
      cnt_nxt = (cnt == TOV) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge WSHARB_CLKIN) begin
    if (WSHARB_RSTIN) begin
      state         <= ARB_IDLE;
      ptr           <= IW'(N_MSTR - 1);
      cnt           <= '0;
      WSHARB_GNT    <= '0;
      WSHARB_GNTIDX <= '0;
      WSHARB_ERROUT <= 1'b0;
    end else begin
      WSHARB_ERROUT <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            WSHARB_GNT    <= pick_hot;
            WSHARB_GNTIDX <= pick_idx;
            ptr           <= pick_idx;
            state         <= ARB_OWN;
          end else begin
            WSHARB_GNT <= '0;
          end
        end
        ARB_OWN: begin
          if (!own_cyc && !own_lock) begin
            WSHARB_GNT <= '0;
            cnt        <= '0;
            state      <= ARB_IDLE;
          end else if (!own_cyc) begin
            // Locked gap between cycles: keep the bus.
            cnt <= cnt_nxt;
          end else if (WSHARB_RETRYIN && !own_lock && others) begin
            WSHARB_GNT <= '0;
            cnt        <= '0;
            state      <= ARB_IDLE;
          end else if (WSHARB_RETRYIN) begin
            cnt <= '0;
          end else if (WSHARB_STBOUT && !term && cnt == TOV) begin
            WSHARB_ERROUT <= 1'b1;
            cnt           <= '0;
            state         <= ARB_TOERR;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        ARB_TOERR: begin
          cnt   <= '0;
          state <= ARB_OWN;
        end
        default: begin
          WSHARB_GNT <= '0;
          cnt        <= '0;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrisc_wishbone_arbiter.sv
// Directed bench for nrisc_wishbone_arbiter (4 masters, TIMEOUT=4).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_nrisc_wishbone_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cyc, stb, lock;
  logic       ack, err, rty;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic       stbo, erro;

  int checks = 0;
  int errors = 0;
  int gcnt [4];
  int expm;

  nrisc_wishbone_arbiter #(
    .N_MSTR  (4),
    .TIMEOUT (4)
  ) dut (
    .WSHARB_CLKIN   (clk),
    .WSHARB_RSTIN   (rst),
    .WSHARB_CYCIN   (cyc),
    .WSHARB_STBIN   (stb),
    .WSHARB_LOCKIN  (lock),
    .WSHARB_ACKIN   (ack),
    .WSHARB_ERRIN   (err),
    .WSHARB_RETRYIN (rty),
    .WSHARB_GNT     (gnt),
    .WSHARB_GNTIDX  (gidx),
    .WSHARB_STBOUT  (stbo),
    .WSHARB_ERROUT  (erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; lock = '0;
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gidx), 32'h0);
    chk("rst_err", 32'(erro), 32'h0);
    chk("rst_stb", 32'(stbo), 32'h0);

    // first grant and three acked beats
    cyc = 4'b1111; stb = 4'b1111;
    tick();
    chk("g0_gnt", 32'(gnt), 32'h1);
    chk("g0_idx", 32'(gidx), 32'h0);
    chk("g0_stb", 32'(stbo), 32'h1);
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("beat_gnt", 32'(gnt), 32'h1);
    end
    ack = 1'b0; cyc = 4'b1110; stb = 4'b1110;
    tick();
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_stb", 32'(stbo), 32'h0);
    cyc = 4'b1111; stb = 4'b1111;
    tick();
    chk("g1_gnt", 32'(gnt), 32'h2);

    // fairness: 40 single-beat transfers starting at master 1
    expm = 1;
    for (int m = 0; m < 4; m++) gcnt[m] = 0;
    for (int t = 0; t < 40; t++) begin
      chk("rr_gnt", 32'(gnt), 32'(1 << expm));
      for (int m = 0; m < 4; m++) if (gnt[m]) gcnt[m]++;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      cyc = 4'b1111 & ~gnt; stb = cyc;
      tick();
      chk("rr_gap", 32'(gnt), 32'h0);
      cyc = 4'b1111; stb = 4'b1111;
      tick();
      expm = (expm + 1) % 4;
    end
    for (int m = 0; m < 4; m++) chk("rr_share", 32'(gcnt[m]), 32'd10);
    cyc = '0; stb = '0;
    tick();
    chk("rr_end", 32'(gnt), 32'h0);

    // lock hold: ptr=1, masters 1 and 2 ask, 2 wins
    cyc = 4'b0110; stb = 4'b0110; lock = 4'b0100;
    tick();
    chk("lk_gnt", 32'(gnt), 32'h4);
    ack = 1'b1;
    tick();
    ack = 1'b0; cyc = 4'b0010; stb = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lk_hold", 32'(gnt), 32'h4);
      chk("lk_stb", 32'(stbo), 32'h0);
    end
    lock = '0;
    tick();
    chk("lk_rel", 32'(gnt), 32'h0);
    tick();
    chk("lk_next", 32'(gnt), 32'h2);
    cyc = '0; stb = '0;
    tick();

    // retry yield
    cyc = 4'b0001; stb = 4'b0001;
    tick();
    chk("ry_own", 32'(gnt), 32'h1);
    cyc = 4'b1001; stb = 4'b1001; rty = 1'b1;
    tick();
    chk("ry_yield", 32'(gnt), 32'h0);
    rty = 1'b0;
    tick();
    chk("ry_next", 32'(gnt), 32'h8);
    chk("ry_idx", 32'(gidx), 32'h3);
    cyc = 4'b0001; stb = 4'b0001;
    tick();
    tick();
    chk("ry_back", 32'(gnt), 32'h1);
    cyc = 4'b1001; stb = 4'b1001; lock = 4'b0001; rty = 1'b1;
    tick();
    chk("ry_lock1", 32'(gnt), 32'h1);
    tick();
    chk("ry_lock2", 32'(gnt), 32'h1);
    rty = 1'b0; cyc = '0; stb = '0; lock = '0;
    tick();
    chk("ry_end", 32'(gnt), 32'h0);

    // timeout: master 1 strobes with no response
    cyc = 4'b0010;
    tick();
    chk("to_gnt", 32'(gnt), 32'h2);
    stb = 4'b0010;
    #0;
    chk("to_stb0", 32'(stbo), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_noerr", 32'(erro), 32'h0);
      chk("to_stb", 32'(stbo), 32'h1);
    end
    tick();
    chk("to_err", 32'(erro), 32'h1);
    chk("to_errstb", 32'(stbo), 32'h0);
    stb = '0;
    tick();
    chk("to_pulse", 32'(erro), 32'h0);
    chk("to_keep", 32'(gnt), 32'h2);
    tick();
    chk("to_once", 32'(erro), 32'h0);

    // ack lands in the counter==4 cycle: no error
    stb = 4'b0010;
    for (int i = 1; i <= 4; i++) tick();
    chk("ta_stb", 32'(stbo), 32'h1);
    ack = 1'b1;
    tick();
    chk("ta_noerr", 32'(erro), 32'h0);
    ack = 1'b0; stb = '0;
    tick();
    chk("ta_noerr2", 32'(erro), 32'h0);
    cyc = '0;
    tick();

    // reset during a locked transfer
    cyc = 4'b1000; stb = 4'b1000; lock = 4'b1000;
    tick();
    chk("rm_gnt", 32'(gnt), 32'h8);
    chk("rm_idx", 32'(gidx), 32'h3);
    rst = 1'b1;
    tick();
    chk("rm_gnt0", 32'(gnt), 32'h0);
    chk("rm_idx0", 32'(gidx), 32'h0);
    chk("rm_stb0", 32'(stbo), 32'h0);
    chk("rm_err0", 32'(erro), 32'h0);
    rst = 1'b0; cyc = 4'b1001; stb = 4'b1001;
    tick();
    chk("rm_next", 32'(gnt), 32'h1);
    chk("rm_nidx", 32'(gidx), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
